// File: rtl/dac_sched_pkg.sv
// Shared constants for the DAC sample scheduler.
// Holds the FSM state encoding (also visible on the state debug port)
// and the default sample width.
package dac_sched_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_PRIME    = 2'd1;
  localparam logic [STATE_W-1:0] ST_RUN      = 2'd2;
  localparam logic [STATE_W-1:0] ST_UNDERRUN = 2'd3;

  localparam int unsigned DEFAULT_DW = 8;

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous FIFO for buffering upstream samples ahead of the DAC.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush_i      empties the FIFO (wins over push/pop)
//   push_i       write wdata_i (ignored when full)
//   pop_i        advance the read pointer (ignored when empty)
//   wdata_i      write data
//   rdata_o      head-of-FIFO data
//   full_o       FIFO full
//   empty_o      FIFO empty
//   level_o      current occupancy
module dac_sample_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok) begin
        count_q <= count_q + LW'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - LW'(1);
      end
    end
  end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces FIR output samples into the DAC output register at a programmable rate.
// Samples are buffered in a FIFO, which must reach PRIME_LVL before playout
// starts or resumes; one sample is issued per rate tick, and a tick that finds
// the FIFO empty raises a sticky underrun flag.
// Optional feature macro: DAC_OFFSET_BINARY_EN (two's complement in,
// offset binary out, mid-scale idle code).
// Ports:
//   clk, rst_n     clock, async active-low reset
//   enable_i       1 = run, 0 = flush FIFO and idle
//   rate_div_i     sample period in clk cycles, minus 1
//   clr_status_i   clears sticky underrun (a same-cycle set wins)
//   s_data_i       upstream sample
//   s_valid_i      upstream sample valid
//   s_ready_o      FIFO can accept a sample (combinational)
//   da_data_o      registered DAC code
//   da_strobe_o    one-cycle pulse coincident with a da_data_o update
//   underrun_o     sticky underrun flag
//   fifo_level_o   FIFO occupancy
//   state_o        FSM state, for debug
module dac_sample_scheduler import dac_sched_pkg::*; #(
  parameter int unsigned DW         = DEFAULT_DW,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PRIME_LVL  = 4,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic [DIV_W-1:0]   rate_div_i,
  input  logic               clr_status_i,
  input  logic [DW-1:0]      s_data_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic [DW-1:0]      da_data_o,
  output logic               da_strobe_o,
  output logic               underrun_o,
  output logic [LVL_W-1:0]   fifo_level_o,
  output logic [STATE_W-1:0] state_o
);

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [DW-1:0] IDLE_CODE = {1'b1, {(DW-1){1'b0}}};
  function automatic logic [DW-1:0] to_dac(input logic [DW-1:0] s);
    return {~s[DW-1], s[DW-2:0]};
  endfunction
`else
  localparam logic [DW-1:0] IDLE_CODE = '0;
  function automatic logic [DW-1:0] to_dac(input logic [DW-1:0] s);
    return s;
  endfunction
`endif

  logic [STATE_W-1:0] state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      da_data_q, da_data_d;
  logic               strobe_q, strobe_d;
  logic               underrun_q, underrun_d;

  logic               fifo_full, fifo_empty;
  logic [DW-1:0]      fifo_rdata;
  logic [LVL_W-1:0]   fifo_level;
  logic               run, tick, primed, push, pop, underrun_set;

  assign run          = (state_q == ST_RUN);
  assign tick         = run && (cnt_q == rate_div_i);
  assign primed       = (fifo_level >= LVL_W'(PRIME_LVL));
  assign s_ready_o    = (state_q != ST_IDLE) && !fifo_full;
  assign push         = s_valid_i && s_ready_o;
  // Disable overrides everything: no pop, no strobe, no status set.
  assign pop          = enable_i && tick && !fifo_empty;
  assign underrun_set = enable_i && tick && fifo_empty;

  dac_sample_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (!enable_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (s_data_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_PRIME;
        ST_PRIME:    if (primed) state_d = ST_RUN;
        ST_RUN:      if (underrun_set) state_d = ST_UNDERRUN;
        ST_UNDERRUN: if (primed) state_d = ST_RUN;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Counter only runs in RUN, so every entry into RUN restarts it at 0.
  assign cnt_d      = (enable_i && run && !tick) ? cnt_q + DIV_W'(1) : '0;
  assign da_data_d  = pop ? to_dac(fifo_rdata) : da_data_q;
  assign strobe_d   = pop;
  assign underrun_d = underrun_set ? 1'b1 : (clr_status_i ? 1'b0 : underrun_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      da_data_q  <= IDLE_CODE;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      da_data_q  <= da_data_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign da_data_o    = da_data_q;
  assign da_strobe_o  = strobe_q;
  assign underrun_o   = underrun_q;
  assign fifo_level_o = fifo_level;
  assign state_o      = state_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Self-checking bench for dac_sample_scheduler: a directed vector table for
// pacing/underrun, hand sequences for backpressure, streaming, disable and
// reset, and randomized traffic against a queue-based reference model.
module tb_dac_sample_scheduler;

  localparam int DEPTH = 8;
  localparam int PRIME = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] rate_div = '0;
  logic        clr = 1'b0;
  logic [7:0]  s_data = '0;
  logic        valid = 1'b0;
  logic        s_ready;
  logic [7:0]  da_data;
  logic        da_strobe;
  logic        underrun;
  logic [3:0]  fifo_level;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  dac_sample_scheduler #(
    .DW         (8),
    .DIV_W      (16),
    .FIFO_DEPTH (DEPTH),
    .PRIME_LVL  (PRIME)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable),
    .rate_div_i   (rate_div),
    .clr_status_i (clr),
    .s_data_i     (s_data),
    .s_valid_i    (valid),
    .s_ready_o    (s_ready),
    .da_data_o    (da_data),
    .da_strobe_o  (da_strobe),
    .underrun_o   (underrun),
    .fifo_level_o (fifo_level),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] conv(input logic [7:0] x);
`ifdef DAC_OFFSET_BINARY_EN
    return x ^ 8'h80;
`else
    return x;
`endif
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  int         m_state;
  int         m_cnt;
  logic [7:0] m_da;
  bit         m_strobe;
  bit         m_ur;

  task automatic model_reset();
    m_q.delete();
    m_state  = 0;
    m_cnt    = 0;
    m_da     = conv(8'h00);
    m_strobe = 0;
    m_ur     = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int  sz;
    int  nst;
    bit  tick;
    bit  push;
    bit  uset;
    sz       = m_q.size();
    tick     = (m_state == 2) && (m_cnt == int'(rate_div));
    push     = valid && (m_state != 0) && (sz < DEPTH);
    uset     = 0;
    m_strobe = 0;
    if (!enable) begin
      m_q.delete();
      m_state = 0;
      m_cnt   = 0;
    end else begin
      nst = m_state;
      case (m_state)
        0: nst = 1;
        1: if (sz >= PRIME) nst = 2;
        2: if (tick) begin
             if (sz > 0) begin
               m_da     = conv(m_q.pop_front());
               m_strobe = 1;
             end else begin
               nst  = 3;
               uset = 1;
             end
           end
        default: if (sz >= PRIME) nst = 2;
      endcase
      m_cnt = (m_state == 2 && !tick) ? m_cnt + 1 : 0;
      if (push) m_q.push_back(s_data);
      m_state = nst;
    end
    if (uset) m_ur = 1;
    else if (clr) m_ur = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("level", 32'(fifo_level), 32'(m_q.size()));
    chk("da_data", 32'(da_data), 32'(m_da));
    chk("strobe", 32'(da_strobe), 32'(m_strobe));
    chk("underrun", 32'(underrun), 32'(m_ur));
    chk("s_ready", 32'(s_ready), 32'((m_state != 0) && (m_q.size() < DEPTH)));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_da"}, 32'(da_data), 32'(conv(8'h00)));
    chk({tag, "_strobe"}, 32'(da_strobe), 0);
    chk({tag, "_underrun"}, 32'(underrun), 0);
    chk({tag, "_ready"}, 32'(s_ready), 0);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         en;
    bit         vld;
    logic [7:0] data;
    int         st;
    int         lvl;
    bit         strb;
    logic [7:0] da;   // raw sample; expected code is conv(da)
    bit         ur;
    bit         rdy;
  } vec_t;

  vec_t vec[26];

  initial begin
    int acc;
    int k;
    bit seen;
    logic [7:0] held;

    // Pacing with rate_div=3 through to the first underrun.
    vec[0]  = '{1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1};
    vec[1]  = '{1, 1, 8'h10, 1, 1, 0, 8'h00, 0, 1};
    vec[2]  = '{1, 1, 8'h11, 1, 2, 0, 8'h00, 0, 1};
    vec[3]  = '{1, 1, 8'h12, 1, 3, 0, 8'h00, 0, 1};
    vec[4]  = '{1, 1, 8'h13, 1, 4, 0, 8'h00, 0, 1};
    vec[5]  = '{1, 0, 8'h00, 2, 4, 0, 8'h00, 0, 1};
    vec[6]  = '{1, 0, 8'h00, 2, 4, 0, 8'h00, 0, 1};
    vec[7]  = '{1, 0, 8'h00, 2, 4, 0, 8'h00, 0, 1};
    vec[8]  = '{1, 0, 8'h00, 2, 4, 0, 8'h00, 0, 1};
    vec[9]  = '{1, 0, 8'h00, 2, 3, 1, 8'h10, 0, 1};
    vec[10] = '{1, 0, 8'h00, 2, 3, 0, 8'h10, 0, 1};
    vec[11] = '{1, 0, 8'h00, 2, 3, 0, 8'h10, 0, 1};
    vec[12] = '{1, 0, 8'h00, 2, 3, 0, 8'h10, 0, 1};
    vec[13] = '{1, 0, 8'h00, 2, 2, 1, 8'h11, 0, 1};
    vec[14] = '{1, 0, 8'h00, 2, 2, 0, 8'h11, 0, 1};
    vec[15] = '{1, 0, 8'h00, 2, 2, 0, 8'h11, 0, 1};
    vec[16] = '{1, 0, 8'h00, 2, 2, 0, 8'h11, 0, 1};
    vec[17] = '{1, 0, 8'h00, 2, 1, 1, 8'h12, 0, 1};
    vec[18] = '{1, 0, 8'h00, 2, 1, 0, 8'h12, 0, 1};
    vec[19] = '{1, 0, 8'h00, 2, 1, 0, 8'h12, 0, 1};
    vec[20] = '{1, 0, 8'h00, 2, 1, 0, 8'h12, 0, 1};
    vec[21] = '{1, 0, 8'h00, 2, 0, 1, 8'h13, 0, 1};
    vec[22] = '{1, 0, 8'h00, 2, 0, 0, 8'h13, 0, 1};
    vec[23] = '{1, 0, 8'h00, 2, 0, 0, 8'h13, 0, 1};
    vec[24] = '{1, 0, 8'h00, 2, 0, 0, 8'h13, 0, 1};
    vec[25] = '{1, 0, 8'h00, 3, 0, 0, 8'h13, 1, 1};

    // Power-on reset.
    model_reset();
    #12;
    chk_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Pacing and underrun entry.
    rate_div = 16'd3;
    for (int i = 0; i < 26; i++) begin
      enable = vec[i].en;
      valid  = vec[i].vld;
      s_data = vec[i].data;
      step();
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vec[i].st));
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vec[i].lvl));
      chk($sformatf("vec%0d_strobe", i), 32'(da_strobe), 32'(vec[i].strb));
      chk($sformatf("vec%0d_da", i), 32'(da_data), 32'(conv(vec[i].da)));
      chk($sformatf("vec%0d_ur", i), 32'(underrun), 32'(vec[i].ur));
      chk($sformatf("vec%0d_rdy", i), 32'(s_ready), 32'(vec[i].rdy));
    end

    // Underrun recovery, then clear.
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'h20 + 8'(i);
      step();
    end
    valid = 1'b0;
    chk("ur_refill_level", 32'(fifo_level), 4);
    chk("ur_still_set", 32'(underrun), 1);
    step();
    chk("ur_resume_state", 32'(state), 2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ur_cleared", 32'(underrun), 0);

    // Backpressure with a slow rate.
    enable = 1'b0;
    step();
    rate_div = 16'd100;
    enable   = 1'b1;
    valid    = 1'b1;
    acc      = 0;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'h40 + 8'(acc);
      if (s_ready) acc++;
      step();
    end
    chk("bp_accepted", 32'(acc), 8);
    chk("bp_level_full", 32'(fifo_level), 8);
    chk("bp_ready_low", 32'(s_ready), 0);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      s_data = 8'h40 + 8'(acc);
      if (s_ready) acc++;
      step();
      seen = da_strobe;
    end
    chk("bp_strobe_seen", 32'(seen), 1);
    chk("bp_first_da", 32'(da_data), 32'(conv(8'h40)));
    for (int i = 0; i < 3; i++) begin
      s_data = 8'h40 + 8'(acc);
      if (s_ready) acc++;
      step();
    end
    chk("bp_one_more", 32'(acc), 9);
    chk("bp_level_refull", 32'(fifo_level), 8);

    // Streaming at one sample per cycle.
    valid  = 1'b0;
    enable = 1'b0;
    step();
    rate_div = 16'd0;
    enable   = 1'b1;
    step();
    valid = 1'b1;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'h60 + 8'(k);
      k++;
      step();
    end
    chk("st_enter_run", 32'(state), 2);
    for (int j = 0; j < 16; j++) begin
      s_data = 8'h60 + 8'(k);
      k++;
      step();
      chk($sformatf("st_strobe%0d", j), 32'(da_strobe), 1);
      chk($sformatf("st_level%0d", j), 32'(fifo_level), 5);
      chk($sformatf("st_da%0d", j), 32'(da_data), 32'(conv(8'h60 + 8'(j))));
    end

    // Disable mid-RUN.
    held   = da_data;
    valid  = 1'b0;
    enable = 1'b0;
    step();
    chk("dis_state", 32'(state), 0);
    chk("dis_level", 32'(fifo_level), 0);
    chk("dis_ready", 32'(s_ready), 0);
    chk("dis_da_hold", 32'(da_data), 32'(held));
    chk("dis_strobe", 32'(da_strobe), 0);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 6; seg++) begin
      enable = 1'b0;
      valid  = 1'b0;
      clr    = 1'b0;
      step();
      rate_div = 16'($urandom_range(0, 4));
      for (int c = 0; c < 250; c++) begin
        enable = ($urandom_range(0, 199) != 0);
        valid  = ($urandom_range(0, 99) < 20 + seg * 15);
        s_data = 8'($urandom);
        clr    = ($urandom_range(0, 19) == 0);
        step();
      end
    end
    clr = 1'b0;

    // Async reset in the middle of RUN.
    enable = 1'b0;
    valid  = 1'b0;
    step();
    rate_div = 16'd2;
    enable   = 1'b1;
    valid    = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_data = 8'h7F - 8'(i);
      step();
    end
    valid = 1'b0;
    chk("rst_pre_state", 32'(state), 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_values("rst_mid");
    @(posedge clk);
    #1;
    chk_reset_values("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
